// File: rtl/core_mem_master.sv
// AXI4-Lite master for the load/store unit: one byte/half/word request at a time, aligned bus
// address, lane steering, and sign/zero-extended load data. Optional macro: CORE_MEM_MASTER_BUS_ERR_EN.
module core_mem_master #(
  parameter int unsigned ADDR_W = 32,
  parameter logic [2:0]  AXPROT = 3'b000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] axi_araddr,
  output logic              axi_arvalid,
  output logic [2:0]        axi_arprot,
  input  logic              axi_arready,
  input  logic [31:0]       axi_rdata,
  input  logic [1:0]        axi_rresp,
  input  logic              axi_rvalid,
  output logic              axi_rready,
  output logic [ADDR_W-1:0] axi_awaddr,
  output logic              axi_awvalid,
  output logic [2:0]        axi_awprot,
  input  logic              axi_awready,
  output logic [31:0]       axi_wdata,
  output logic [3:0]        axi_wstrb,
  output logic              axi_wvalid,
  input  logic              axi_wready,
  input  logic [1:0]        axi_bresp,
  input  logic              axi_bvalid,
  output logic              axi_bready
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_AR, S_RD_R, S_WR_AWW, S_WR_B, S_ERR
  } state_t;

  state_t            r_state, w_state_next;
  logic [ADDR_W-1:0] r_addr, w_addr_next;
  logic [1:0]        r_lane, w_lane_next;
  logic [1:0]        r_size, w_size_next;
  logic              r_unsigned, w_unsigned_next;
  logic [31:0]       r_wdata, w_wdata_next;
  logic [3:0]        r_wstrb, w_wstrb_next;
  logic              r_arvalid, w_arvalid_next;
  logic              r_rready, w_rready_next;
  logic              r_awvalid, w_awvalid_next;
  logic              r_wvalid, w_wvalid_next;
  logic              r_bready, w_bready_next;
  logic              r_resp_valid, w_resp_valid_next;
  logic [31:0]       r_resp_rdata, w_resp_rdata_next;
  logic              r_resp_err, w_resp_err_next;

  logic              w_bad_req;
  logic [31:0]       w_lane_wdata;
  logic [3:0]        w_lane_wstrb;
  logic [31:0]       w_shifted;
  logic [31:0]       w_load_data;
  logic              w_rd_err;
  logic              w_wr_err;

`ifdef CORE_MEM_MASTER_BUS_ERR_EN
  assign w_rd_err = (axi_rresp != 2'b00);
  assign w_wr_err = (axi_bresp != 2'b00);
`else
  // Response codes are deliberately ignored in this build.
  logic w_unused_resp;
  assign w_unused_resp = ^{axi_rresp, axi_bresp};
  assign w_rd_err      = 1'b0;
  assign w_wr_err      = 1'b0;
`endif

  assign w_bad_req = (req_size == 2'b11) ||
                     ((req_size == 2'b01) && req_addr[0]) ||
                     ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

  always_comb begin
    w_lane_wdata = req_wdata;
    w_lane_wstrb = 4'b1111;
    case (req_size)
      2'b00: begin
        w_lane_wdata = {4{req_wdata[7:0]}};
        w_lane_wstrb = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        w_lane_wdata = {2{req_wdata[15:0]}};
        w_lane_wstrb = 4'b0011 << req_addr[1:0];
      end
      default: begin
        w_lane_wdata = req_wdata;
        w_lane_wstrb = 4'b1111;
      end
    endcase
  end

  // Bring the addressed byte/half down to bit 0 before extending.
  assign w_shifted = axi_rdata >> {r_lane, 3'b000};

  always_comb begin
    w_load_data = w_shifted;
    case (r_size)
      2'b00:   w_load_data = r_unsigned ? {24'h0, w_shifted[7:0]}
                                        : {{24{w_shifted[7]}}, w_shifted[7:0]};
      2'b01:   w_load_data = r_unsigned ? {16'h0, w_shifted[15:0]}
                                        : {{16{w_shifted[15]}}, w_shifted[15:0]};
      default: w_load_data = w_shifted;
    endcase
  end

  always_comb begin
    w_state_next      = r_state;
    w_addr_next       = r_addr;
    w_lane_next       = r_lane;
    w_size_next       = r_size;
    w_unsigned_next   = r_unsigned;
    w_wdata_next      = r_wdata;
    w_wstrb_next      = r_wstrb;
    w_arvalid_next    = r_arvalid;
    w_rready_next     = r_rready;
    w_awvalid_next    = r_awvalid;
    w_wvalid_next     = r_wvalid;
    w_bready_next     = r_bready;
    w_resp_valid_next = 1'b0;
    w_resp_rdata_next = r_resp_rdata;
    w_resp_err_next   = r_resp_err;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_addr_next     = {req_addr[ADDR_W-1:2], 2'b00};
          w_lane_next     = req_addr[1:0];
          w_size_next     = req_size;
          w_unsigned_next = req_unsigned;
          w_wdata_next    = w_lane_wdata;
          w_wstrb_next    = w_lane_wstrb;
          if (w_bad_req) begin
            // Error response is issued straight away; ERR just spends the busy cycle.
            w_state_next      = S_ERR;
            w_resp_valid_next = 1'b1;
            w_resp_rdata_next = 32'h0;
            w_resp_err_next   = 1'b1;
          end else if (req_we) begin
            w_state_next   = S_WR_AWW;
            w_awvalid_next = 1'b1;
            w_wvalid_next  = 1'b1;
          end else begin
            w_state_next   = S_RD_AR;
            w_arvalid_next = 1'b1;
          end
        end
      end
      S_RD_AR: begin
        if (axi_arready) begin
          w_arvalid_next = 1'b0;
          w_rready_next  = 1'b1;
          w_state_next   = S_RD_R;
        end
      end
      S_RD_R: begin
        if (axi_rvalid) begin
          w_rready_next     = 1'b0;
          w_state_next      = S_IDLE;
          w_resp_valid_next = 1'b1;
          w_resp_rdata_next = w_load_data;
          w_resp_err_next   = w_rd_err;
        end
      end
      S_WR_AWW: begin
        if (r_awvalid && axi_awready) w_awvalid_next = 1'b0;
        if (r_wvalid && axi_wready)   w_wvalid_next  = 1'b0;
        if ((!r_awvalid || axi_awready) && (!r_wvalid || axi_wready)) begin
          w_state_next  = S_WR_B;
          w_bready_next = 1'b1;
        end
      end
      S_WR_B: begin
        if (axi_bvalid) begin
          w_bready_next     = 1'b0;
          w_state_next      = S_IDLE;
          w_resp_valid_next = 1'b1;
          w_resp_rdata_next = 32'h0;
          w_resp_err_next   = w_wr_err;
        end
      end
      S_ERR:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_lane       <= 2'b00;
      r_size       <= 2'b00;
      r_unsigned   <= 1'b0;
      r_wdata      <= 32'h0;
      r_wstrb      <= 4'h0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'h0;
      r_resp_err   <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_addr       <= w_addr_next;
      r_lane       <= w_lane_next;
      r_size       <= w_size_next;
      r_unsigned   <= w_unsigned_next;
      r_wdata      <= w_wdata_next;
      r_wstrb      <= w_wstrb_next;
      r_arvalid    <= w_arvalid_next;
      r_rready     <= w_rready_next;
      r_awvalid    <= w_awvalid_next;
      r_wvalid     <= w_wvalid_next;
      r_bready     <= w_bready_next;
      r_resp_valid <= w_resp_valid_next;
      r_resp_rdata <= w_resp_rdata_next;
      r_resp_err   <= w_resp_err_next;
    end
  end

  assign req_ready   = (r_state == S_IDLE);
  assign resp_valid  = r_resp_valid;
  assign resp_rdata  = r_resp_rdata;
  assign resp_err    = r_resp_err;
  assign axi_araddr  = r_addr;
  assign axi_arvalid = r_arvalid;
  assign axi_arprot  = AXPROT;
  assign axi_rready  = r_rready;
  assign axi_awaddr  = r_addr;
  assign axi_awvalid = r_awvalid;
  assign axi_awprot  = AXPROT;
  assign axi_wdata   = r_wdata;
  assign axi_wstrb   = r_wstrb;
  assign axi_wvalid  = r_wvalid;
  assign axi_bready  = r_bready;

endmodule

// File: tb/tb_core_mem_master.sv
// Directed bench for core_mem_master: the bench plays the AXI-Lite slave cycle by cycle
// and compares every observed value against hand-computed constants.
module tb_core_mem_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] axi_araddr, axi_awaddr, axi_rdata, axi_wdata;
  logic        axi_arvalid, axi_arready, axi_rvalid, axi_rready;
  logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_bvalid, axi_bready;
  logic [2:0]  axi_arprot, axi_awprot;
  logic [1:0]  axi_rresp, axi_bresp;
  logic [3:0]  axi_wstrb;

  int n_checks = 0;
  int n_errors = 0;

`ifdef CORE_MEM_MASTER_BUS_ERR_EN
  localparam logic BUS_ERR = 1'b1;
`else
  localparam logic BUS_ERR = 1'b0;
`endif

  always #5 clk = ~clk;

  core_mem_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arprot(axi_arprot),
    .axi_arready(axi_arready), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awprot(axi_awprot),
    .axi_awready(axi_awready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  // Present a request for one cycle, then scramble the fields to prove they were captured.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] data, input string tag);
    check_eq({tag, " req_ready"}, req_ready, 1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = data;
    tick;
    req_valid = 1'b0; req_we = ~we; req_size = 2'b10; req_unsigned = ~uns;
    req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A;
  endtask

  task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input int ar_d, input logic [31:0] rdata,
                         input logic [1:0] rresp, input logic [31:0] exp_araddr,
                         input logic [31:0] exp_data, input logic exp_err);
    issue(1'b0, size, uns, addr, 32'h0, tag);
    check_eq({tag, " arvalid"}, axi_arvalid, 1);
    check_eq({tag, " araddr"}, axi_araddr, exp_araddr);
    repeat (ar_d) begin
      tick;
      check_eq({tag, " arvalid held"}, axi_arvalid, 1);
    end
    axi_arready = 1'b1;
    tick;
    axi_arready = 1'b0;
    check_eq({tag, " arvalid drop"}, axi_arvalid, 0);
    check_eq({tag, " rready"}, axi_rready, 1);
    tick;
    check_eq({tag, " rready held"}, axi_rready, 1);
    check_eq({tag, " no early resp"}, resp_valid, 0);
    axi_rvalid = 1'b1; axi_rdata = rdata; axi_rresp = rresp;
    tick;
    axi_rvalid = 1'b0; axi_rdata = 32'hDEAD_BEEF; axi_rresp = 2'b00;
    check_eq({tag, " resp_valid"}, resp_valid, 1);
    check_eq({tag, " rdata"}, resp_rdata, exp_data);
    check_eq({tag, " err"}, resp_err, exp_err);
    check_eq({tag, " rready drop"}, axi_rready, 0);
    $display("load  %s addr=0x%08h rdata=0x%08h -> 0x%08h err=%0b", tag, addr, rdata,
             resp_rdata, resp_err);
  endtask

  task automatic do_store(input string tag, input logic [31:0] addr, input logic [1:0] size,
                          input logic [31:0] data, input int aw_d, input int w_d,
                          input logic [1:0] bresp, input logic [31:0] exp_awaddr,
                          input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb,
                          input logic exp_err);
    bit aw_done = 0;
    bit w_done = 0;
    int cyc = 0;
    issue(1'b1, size, 1'b0, addr, data, tag);
    check_eq({tag, " awvalid"}, axi_awvalid, 1);
    check_eq({tag, " wvalid"}, axi_wvalid, 1);
    check_eq({tag, " awaddr"}, axi_awaddr, exp_awaddr);
    check_eq({tag, " wdata"}, axi_wdata, exp_wdata);
    check_eq({tag, " wstrb"}, {28'h0, axi_wstrb}, {28'h0, exp_wstrb});
    while (!(aw_done && w_done) && cyc < 30) begin
      axi_awready = !aw_done && (cyc >= aw_d);
      axi_wready  = !w_done && (cyc >= w_d);
      tick;
      if (axi_awready) begin
        aw_done = 1;
        check_eq({tag, " awvalid drop"}, axi_awvalid, 0);
      end
      if (axi_wready) begin
        w_done = 1;
        check_eq({tag, " wvalid drop"}, axi_wvalid, 0);
      end
      if (!aw_done) check_eq({tag, " awvalid held"}, axi_awvalid, 1);
      if (!w_done)  check_eq({tag, " wvalid held"}, axi_wvalid, 1);
      axi_awready = 1'b0; axi_wready = 1'b0;
      cyc++;
    end
    check_eq({tag, " aw/w done in budget"}, {31'h0, aw_done && w_done}, 1);
    check_eq({tag, " bready"}, axi_bready, 1);
    check_eq({tag, " no early resp"}, resp_valid, 0);
    axi_bvalid = 1'b1; axi_bresp = bresp;
    tick;
    axi_bvalid = 1'b0; axi_bresp = 2'b00;
    check_eq({tag, " resp_valid"}, resp_valid, 1);
    check_eq({tag, " err"}, resp_err, exp_err);
    check_eq({tag, " rdata zero"}, resp_rdata, 32'h0);
    check_eq({tag, " bready drop"}, axi_bready, 0);
    tick;
    check_eq({tag, " resp pulse"}, resp_valid, 0);
    $display("store %s addr=0x%08h wdata=0x%08h wstrb=%b err=%0b", tag, addr, axi_wdata,
             axi_wstrb, resp_err);
  endtask

  task automatic do_bad(input string tag, input logic we, input logic [1:0] size,
                        input logic [31:0] addr);
    bit any_valid = 0;
    issue(we, size, 1'b0, addr, 32'h1234_5678, tag);
    check_eq({tag, " resp_valid"}, resp_valid, 1);
    check_eq({tag, " err"}, resp_err, 1);
    check_eq({tag, " rdata zero"}, resp_rdata, 32'h0);
    repeat (3) begin
      if (axi_arvalid || axi_awvalid || axi_wvalid) any_valid = 1;
      tick;
    end
    check_eq({tag, " no bus valid"}, {31'h0, any_valid}, 0);
    check_eq({tag, " ready again"}, req_ready, 1);
    $display("error %s addr=0x%08h size=%b err=1 expected", tag, addr, size);
  endtask

  initial begin
    bit seen;
    rst = 1'b1;
    req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0;
    axi_arready = 0; axi_rdata = 0; axi_rresp = 0; axi_rvalid = 0;
    axi_awready = 0; axi_wready = 0; axi_bresp = 0; axi_bvalid = 0;
    repeat (3) tick;
    rst = 1'b0;
    tick;
    check_eq("reset arvalid", axi_arvalid, 0);
    check_eq("reset awvalid", axi_awvalid, 0);
    check_eq("reset wvalid", axi_wvalid, 0);
    check_eq("reset rready", axi_rready, 0);
    check_eq("reset bready", axi_bready, 0);
    check_eq("reset resp_valid", resp_valid, 0);
    check_eq("reset resp_rdata", resp_rdata, 0);
    check_eq("reset resp_err", resp_err, 0);
    check_eq("reset req_ready", req_ready, 1);
    check_eq("reset araddr", axi_araddr, 0);
    check_eq("reset wstrb", {28'h0, axi_wstrb}, 0);
    $display("reset released: req_ready=%0b", req_ready);

    do_load("lb_s",  32'h0000_1003, 2'b00, 1'b0, 0, 32'h80FF_1234, 2'b00,
            32'h0000_1000, 32'hFFFF_FF80, 1'b0);
    do_load("lb_u",  32'h0000_1003, 2'b00, 1'b1, 0, 32'h80FF_1234, 2'b00,
            32'h0000_1000, 32'h0000_0080, 1'b0);
    do_load("lh_s",  32'h0000_1002, 2'b01, 1'b0, 2, 32'h80FF_1234, 2'b00,
            32'h0000_1000, 32'hFFFF_80FF, 1'b0);
    do_load("lh_u",  32'h0000_0006, 2'b01, 1'b1, 1, 32'h7A5C_0000, 2'b00,
            32'h0000_0004, 32'h0000_7A5C, 1'b0);
    do_load("lb_pos", 32'h0000_0001, 2'b00, 1'b0, 0, 32'h0000_7F00, 2'b00,
            32'h0000_0000, 32'h0000_007F, 1'b0);
    do_load("lw_slverr", 32'h0000_1000, 2'b10, 1'b0, 0, 32'h80FF_1234, 2'b10,
            32'h0000_1000, 32'h80FF_1234, BUS_ERR);

    do_store("sh", 32'h0000_2002, 2'b01, 32'h0000_BEEF, 0, 3, 2'b00,
             32'h0000_2000, 32'hBEEF_BEEF, 4'b1100, 1'b0);
    do_store("sb_wfirst", 32'h0000_3001, 2'b00, 32'h0000_00A5, 2, 0, 2'b00,
             32'h0000_3000, 32'hA5A5_A5A5, 4'b0010, 1'b0);
    do_store("sw_slverr", 32'h0000_4000, 2'b10, 32'h1234_5678, 0, 0, 2'b10,
             32'h0000_4000, 32'h1234_5678, 4'b1111, BUS_ERR);

    do_bad("lw_mis", 1'b0, 2'b10, 32'h0000_1001);
    do_bad("lh_mis", 1'b0, 2'b01, 32'h0000_1001);
    do_bad("sz_res", 1'b1, 2'b11, 32'h0000_1000);

    // Reset while waiting for R: everything drops immediately, the late rvalid is ignored.
    issue(1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h0, "rst_mid");
    axi_arready = 1'b1;
    tick;
    axi_arready = 1'b0;
    check_eq("rst_mid in RD_R", axi_rready, 1);
    rst = 1'b1;
    #1;
    check_eq("rst_mid rready", axi_rready, 0);
    check_eq("rst_mid arvalid", axi_arvalid, 0);
    check_eq("rst_mid req_ready", req_ready, 1);
    tick;
    rst = 1'b0;
    tick;
    axi_rvalid = 1'b1; axi_rdata = 32'hCAFE_F00D;
    seen = 0;
    repeat (3) begin
      tick;
      axi_rvalid = 1'b0;
      if (resp_valid) seen = 1;
    end
    check_eq("rst_mid no resp", {31'h0, seen}, 0);
    check_eq("rst_mid idle", req_ready, 1);
    $display("reset mid-read: resp seen=%0b", seen);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
